// File: rtl/ball_motion.sv
// +--------------------------------------------------------------------------+
// | ball_motion: steps the ball by the encoder velocity on each move tick,   |
// | reflects off top/bottom walls and flags left/right misses.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ball_motion #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int BALL_SIZE = 8,
   parameter int POS_W     = 10,
   parameter int START_X   = 316,
   parameter int START_Y   = 236
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick_i,
   input  logic             serve_i,
   input  logic [3:0]       in_vector_i,
   output logic [POS_W-1:0] ball_x_o,
   output logic [POS_W-1:0] ball_y_o,
   output logic             dir_x_o,
   output logic             dir_y_o,
   output logic             miss_left_o,
   output logic             miss_right_o,
   output logic             bounce_o
);

   // Two guard bits let the step go below zero or past the limit without wrapping.
   localparam int c_EXT_W = POS_W + 2;

   localparam logic signed [c_EXT_W-1:0] c_ZERO   = '0;
   localparam logic signed [c_EXT_W-1:0] c_XMAX   = c_EXT_W'(SCREEN_W - BALL_SIZE);
   localparam logic signed [c_EXT_W-1:0] c_YMAX   = c_EXT_W'(SCREEN_H - BALL_SIZE);
   localparam logic [POS_W-1:0]          c_XMAX_P = POS_W'(SCREEN_W - BALL_SIZE);
   localparam logic [POS_W-1:0]          c_YMAX_P = POS_W'(SCREEN_H - BALL_SIZE);
   localparam logic [POS_W-1:0]          c_STX    = POS_W'(START_X);
   localparam logic [POS_W-1:0]          c_STY    = POS_W'(START_Y);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      MISS = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [POS_W-1:0]   ball_x_q, ball_x_d;
   logic [POS_W-1:0]   ball_y_q, ball_y_d;
   logic               dir_x_q, dir_x_d;
   logic               dir_y_q, dir_y_d;
   logic               miss_left_q, miss_left_d;
   logic               miss_right_q, miss_right_d;
   logic               bounce_q, bounce_d;

   logic signed [c_EXT_W-1:0] w_dx;
   logic signed [c_EXT_W-1:0] w_dy;
   logic signed [c_EXT_W-1:0] w_nx;
   logic signed [c_EXT_W-1:0] w_ny;

   assign w_dx = {{(c_EXT_W-2){in_vector_i[3]}}, in_vector_i[3:2]};
   assign w_dy = {{(c_EXT_W-2){in_vector_i[1]}}, in_vector_i[1:0]};
   assign w_nx = $signed({2'b00, ball_x_q}) + w_dx;
   assign w_ny = $signed({2'b00, ball_y_q}) + w_dy;

   always_comb begin
      state_d      = state_q;
      ball_x_d     = ball_x_q;
      ball_y_d     = ball_y_q;
      dir_x_d      = dir_x_q;
      dir_y_d      = dir_y_q;
      miss_left_d  = 1'b0;
      miss_right_d = 1'b0;
      bounce_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (serve_i) begin
               state_d = MOVE;
            end
         end

         MOVE: begin
            if (tick_i) begin
               if (w_ny <= c_ZERO) begin
                  ball_y_d = '0;
                  dir_y_d  = 1'b0;
                  bounce_d = 1'b1;
               end else if (w_ny >= c_YMAX) begin
                  ball_y_d = c_YMAX_P;
                  dir_y_d  = 1'b1;
                  bounce_d = 1'b1;
               end else begin
                  ball_y_d = w_ny[POS_W-1:0];
               end

               if (w_nx <= c_ZERO) begin
                  ball_x_d    = '0;
                  miss_left_d = 1'b1;
                  state_d     = MISS;
               end else if (w_nx >= c_XMAX) begin
                  ball_x_d     = c_XMAX_P;
                  miss_right_d = 1'b1;
                  state_d      = MISS;
               end else begin
                  ball_x_d = w_nx[POS_W-1:0];
               end
            end
         end

         MISS: begin
            // Re-serve toward the player who just scored.
            if (tick_i) begin
               ball_x_d = c_STX;
               ball_y_d = c_STY;
               dir_x_d  = ~dir_x_q;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         ball_x_q     <= c_STX;
         ball_y_q     <= c_STY;
         dir_x_q      <= 1'b0;
         dir_y_q      <= 1'b0;
         miss_left_q  <= 1'b0;
         miss_right_q <= 1'b0;
         bounce_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
         miss_left_q  <= miss_left_d;
         miss_right_q <= miss_right_d;
         bounce_q     <= bounce_d;
      end
   end

   assign ball_x_o     = ball_x_q;
   assign ball_y_o     = ball_y_q;
   assign dir_x_o      = dir_x_q;
   assign dir_y_o      = dir_y_q;
   assign miss_left_o  = miss_left_q;
   assign miss_right_o = miss_right_q;
   assign bounce_o     = bounce_q;

endmodule

`default_nettype wire

// File: tb/tb_ball_motion.sv
// +--------------------------------------------------------------------------+
// | tb_ball_motion: scoreboard bench for ball_motion with a reference model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ball_motion;

   localparam int XMAX = 640 - 8;
   localparam int YMAX = 480 - 8;
   localparam int SX   = 316;
   localparam int SY   = 236;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       dx;
      logic       dy;
      logic       ml;
      logic       mr;
      logic       b;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b1;
   logic       serve = 1'b0;
   logic [3:0] vec = 4'b0000;
   logic [9:0] ball_x, ball_y;
   logic       dir_x, dir_y, miss_left, miss_right, bounce;

   int n_cmp = 0;
   int n_bad = 0;
   obs_t sb[$];

   ball_motion dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .tick_i       (tick),
      .serve_i      (serve),
      .in_vector_i  (vec),
      .ball_x_o     (ball_x),
      .ball_y_o     (ball_y),
      .dir_x_o      (dir_x),
      .dir_y_o      (dir_y),
      .miss_left_o  (miss_left),
      .miss_right_o (miss_right),
      .bounce_o     (bounce)
   );

   always #5 clk = ~clk;

   // Reference model: a ball at integer coordinates in one of three modes.
   int  m_x = SX, m_y = SY;
   bit  m_dirx = 0, m_diry = 0;
   int  m_mode = 0;              // 0 waiting for serve, 1 in play, 2 just missed
   int  step_of[4] = '{0, 1, -2, -1};

   function automatic obs_t predict(input bit r, input bit t, input bit s, input logic [3:0] v);
      obs_t e;
      int nx, ny;
      e = '0;
      if (!r) begin
         m_x = SX; m_y = SY; m_dirx = 0; m_diry = 0; m_mode = 0;
      end else if (m_mode == 0) begin
         if (s) m_mode = 1;
      end else if (m_mode == 1) begin
         if (t) begin
            nx = m_x + step_of[v[3:2]];
            ny = m_y + step_of[v[1:0]];
            if (ny <= 0)         begin m_y = 0;    m_diry = 0; e.b = 1; end
            else if (ny >= YMAX) begin m_y = YMAX; m_diry = 1; e.b = 1; end
            else                 m_y = ny;
            if (nx <= 0)         begin m_x = 0;    e.ml = 1; m_mode = 2; end
            else if (nx >= XMAX) begin m_x = XMAX; e.mr = 1; m_mode = 2; end
            else                 m_x = nx;
         end
      end else begin
         if (t) begin
            m_x = SX; m_y = SY; m_dirx = !m_dirx; m_mode = 0;
         end
      end
      e.x  = 10'(m_x);
      e.y  = 10'(m_y);
      e.dx = m_dirx;
      e.dy = m_diry;
      return e;
   endfunction

   task automatic cyc(input bit r, input bit t, input bit s, input logic [3:0] v);
      @(negedge clk);
      rst_n = r;
      tick  = t;
      serve = s;
      vec   = v;
      sb.push_back(predict(r, t, s, v));
   endtask

   task automatic move_ticks(input int n, input logic [3:0] v);
      for (int i = 0; i < n; i++) begin
         cyc(1, 1, 0, v);
         cyc(1, 0, 0, v);
      end
   endtask

   // Monitor: every clock the DUT presents a fresh registered output set.
   initial begin
      obs_t got, exp_o;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_o = sb.pop_front();
            got   = '{ball_x, ball_y, dir_x, dir_y, miss_left, miss_right, bounce};
            n_cmp++;
            if (got !== exp_o) begin
               n_bad++;
               $display("FAIL outputs t=%0t got x=%0d y=%0d dx=%b dy=%b ml=%b mr=%b b=%b exp x=%0d y=%0d dx=%b dy=%b ml=%b mr=%b b=%b",
                        $time, got.x, got.y, got.dx, got.dy, got.ml, got.mr, got.b,
                        exp_o.x, exp_o.y, exp_o.dx, exp_o.dy, exp_o.ml, exp_o.mr, exp_o.b);
            end
         end
      end
   end

   initial begin
      logic [3:0] rv;
      // Reset held with tick and serve active.
      repeat (3) cyc(0, 1, 1, 4'b0101);
      cyc(1, 1, 0, 4'b0101);
      // Serve then diagonal steps.
      cyc(1, 0, 1, 4'b0101);
      move_ticks(4, 4'b0101);
      // Reset coincident with a tick mid-play.
      cyc(0, 1, 0, 4'b0101);
      cyc(1, 0, 0, 4'b0101);
      // Top wall: walk y down to 2, then two -1 steps.
      cyc(1, 1, 1, 4'b0010);
      move_ticks(117, 4'b0010);
      move_ticks(2, 4'b0111);
      // Left miss: walk x to 1, then dx=-2, then reload tick.
      move_ticks(317, 4'b1100);
      move_ticks(1, 4'b1001);
      cyc(1, 0, 1, 4'b0000);
      move_ticks(1, 4'b0000);
      // Corner: reach (631,471), then +1/+1 hits right and bottom together.
      cyc(1, 0, 1, 4'b0000);
      move_ticks(80, 4'b0100);
      move_ticks(235, 4'b0101);
      move_ticks(1, 4'b0101);
      move_ticks(1, 4'b0000);
      // Randomised play.
      rv = 4'($urandom);
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 7) == 0) rv = 4'($urandom);
         cyc(($urandom_range(0, 299) != 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) == 0, rv);
      end
      cyc(1, 0, 0, 4'b0000);
      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
